// File: rtl/key_event_decoder.sv
// key_event_decoder: turns the debounced key level into short/long/double-click pulses.
// Define KEY_REPEAT_EN to add auto-repeat pulses while a long press is held.
module key_event_decoder #(
  parameter logic [31:0] LONG_CYC    = 32'd50_000_000,
  parameter logic [31:0] DBL_GAP_CYC = 32'd15_000_000,
  parameter logic [31:0] REPEAT_CYC  = 32'd10_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic key_level,
  output logic short_pulse,
  output logic long_pulse,
  output logic double_pulse,
  output logic repeat_pulse,
  output logic busy
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    PRESS1    = 3'd1,
    WAIT_GAP  = 3'd2,
    PRESS2    = 3'd3,
    HOLD_LONG = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic        key_prev_q, key_prev_d;
  logic        armed_q, armed_d;
  logic        short_pulse_q, short_pulse_d;
  logic        long_pulse_q, long_pulse_d;
  logic        double_pulse_q, double_pulse_d;
  logic        repeat_pulse_q, repeat_pulse_d;
  logic        busy_q, busy_d;
  logic        rise, fall;

  // armed_q stays low for the first cycle after reset so a key held through
  // reset does not look like a fresh press.
  assign rise = key_level & ~key_prev_q & armed_q;
  assign fall = ~key_level & key_prev_q;

`ifndef KEY_REPEAT_EN
  logic unused_repeat_cfg;
  assign unused_repeat_cfg = ^REPEAT_CYC;
`endif

  always_comb begin
    key_prev_d     = key_level;
    armed_d        = 1'b1;
    state_d        = state_q;
    cnt_d          = cnt_q + 32'd1;
    short_pulse_d  = 1'b0;
    long_pulse_d   = 1'b0;
    double_pulse_d = 1'b0;
    repeat_pulse_d = 1'b0;
    busy_d         = (state_q != IDLE);

    case (state_q)
      IDLE: begin
        if (rise) state_d = PRESS1;
      end
      PRESS1: begin
        if (fall) begin
          state_d = WAIT_GAP;
        end else if (cnt_q == LONG_CYC - 32'd1) begin
          state_d      = HOLD_LONG;
          long_pulse_d = 1'b1;
        end
      end
      WAIT_GAP: begin
        if (rise) begin
          state_d = PRESS2;
        end else if (cnt_q == DBL_GAP_CYC - 32'd1) begin
          state_d       = IDLE;
          short_pulse_d = 1'b1;
        end
      end
      PRESS2: begin
        if (fall) begin
          state_d        = IDLE;
          double_pulse_d = 1'b1;
        end
      end
      HOLD_LONG: begin
`ifdef KEY_REPEAT_EN
        if (fall) begin
          state_d = IDLE;
        end else if (cnt_q == REPEAT_CYC - 32'd1) begin
          cnt_d          = 32'd0;
          repeat_pulse_d = 1'b1;
        end
`else
        cnt_d = 32'd0;
        if (fall) state_d = IDLE;
`endif
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Every state entry restarts the shared counter.
    if (state_d != state_q) cnt_d = 32'd0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      cnt_q          <= 32'd0;
      key_prev_q     <= 1'b0;
      armed_q        <= 1'b0;
      short_pulse_q  <= 1'b0;
      long_pulse_q   <= 1'b0;
      double_pulse_q <= 1'b0;
      repeat_pulse_q <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      key_prev_q     <= key_prev_d;
      armed_q        <= armed_d;
      short_pulse_q  <= short_pulse_d;
      long_pulse_q   <= long_pulse_d;
      double_pulse_q <= double_pulse_d;
      repeat_pulse_q <= repeat_pulse_d;
      busy_q         <= busy_d;
    end
  end

  assign short_pulse  = short_pulse_q;
  assign long_pulse   = long_pulse_q;
  assign double_pulse = double_pulse_q;
  assign repeat_pulse = repeat_pulse_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_key_event_decoder.sv
// Directed bench for key_event_decoder with LONG_CYC=20, DBL_GAP_CYC=10, REPEAT_CYC=5.
module tb_key_event_decoder;

  localparam logic [31:0] LONG_CYC    = 32'd20;
  localparam logic [31:0] DBL_GAP_CYC = 32'd10;
  localparam logic [31:0] REPEAT_CYC  = 32'd5;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic key_level = 1'b0;
  logic short_pulse, long_pulse, double_pulse, repeat_pulse, busy;

  int total = 0;
  int bad = 0;
  int edge_n = 0;
  int n_short = 0, n_long = 0, n_double = 0, n_multi = 0;
  int last_short = -1, last_long = -1, last_double = -1;
  int rep_q[$];

  key_event_decoder #(
    .LONG_CYC(LONG_CYC),
    .DBL_GAP_CYC(DBL_GAP_CYC),
    .REPEAT_CYC(REPEAT_CYC)
  ) dut (
    .clk(clk),
    .reset(reset),
    .key_level(key_level),
    .short_pulse(short_pulse),
    .long_pulse(long_pulse),
    .double_pulse(double_pulse),
    .repeat_pulse(repeat_pulse),
    .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) edge_n <= edge_n + 1;

  // Pulse recorder: each pulse is logged with the index of the edge that set it.
  always @(negedge clk) begin
    if (short_pulse === 1'b1) begin n_short <= n_short + 1; last_short <= edge_n; end
    if (long_pulse === 1'b1) begin n_long <= n_long + 1; last_long <= edge_n; end
    if (double_pulse === 1'b1) begin n_double <= n_double + 1; last_double <= edge_n; end
    if (repeat_pulse === 1'b1) rep_q.push_back(edge_n);
    if ($countones({short_pulse === 1'b1, long_pulse === 1'b1, double_pulse === 1'b1}) > 1)
      n_multi <= n_multi + 1;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required normal completion");
    $fatal(1);
  end

  task automatic test_reset();
    repeat (3) @(negedge clk);
    #1;
    total++;
    if ({short_pulse, long_pulse, double_pulse, repeat_pulse, busy} !== 5'b0) begin
      bad++;
      $display("FAIL reset_outputs: got %b want 00000",
               {short_pulse, long_pulse, double_pulse, repeat_pulse, busy});
    end
    reset = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    total++;
    if ({short_pulse, long_pulse, double_pulse, repeat_pulse, busy} !== 5'b0) begin
      bad++;
      $display("FAIL after_reset_idle: got %b want 00000",
               {short_pulse, long_pulse, double_pulse, repeat_pulse, busy});
    end
  endtask

  task automatic test_short();
    int s_short = n_short, s_long = n_long, s_dbl = n_double, s_rep = rep_q.size();
    int r0, f0;
    @(negedge clk); key_level = 1'b1; r0 = edge_n + 1;
    repeat (5) @(negedge clk);
    key_level = 1'b0; f0 = edge_n + 1;
    while (edge_n < f0 + 10) @(negedge clk);
    #1;
    total++;
    if (short_pulse !== 1'b1 || busy !== 1'b1) begin
      bad++;
      $display("FAIL short_at_gap: short=%b busy=%b want short=1 busy=1", short_pulse, busy);
    end
    @(negedge clk); #1;
    total++;
    if (short_pulse !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL short_after: short=%b busy=%b want short=0 busy=0", short_pulse, busy);
    end
    repeat (20) @(negedge clk); #1;
    total++;
    if (n_short - s_short != 1 || last_short != f0 + 10) begin
      bad++;
      $display("FAIL short_count: count=%0d edge=%0d want count=1 edge=%0d",
               n_short - s_short, last_short, f0 + 10);
    end
    total++;
    if (n_long != s_long || n_double != s_dbl || rep_q.size() != s_rep) begin
      bad++;
      $display("FAIL short_others: long=%0d double=%0d repeat=%0d want 0 0 0",
               n_long - s_long, n_double - s_dbl, rep_q.size() - s_rep);
    end
  endtask

  task automatic test_long();
    int s_short = n_short, s_long = n_long, s_dbl = n_double, s_rep = rep_q.size();
    int r0;
    @(negedge clk); key_level = 1'b1; r0 = edge_n + 1;
    while (edge_n < r0 + 20) @(negedge clk);
    #1;
    total++;
    if (long_pulse !== 1'b1) begin
      bad++;
      $display("FAIL long_at_threshold: long_pulse=%b want 1", long_pulse);
    end
    @(negedge clk); #1;
    total++;
    if (long_pulse !== 1'b0 || busy !== 1'b1) begin
      bad++;
      $display("FAIL long_hold: long=%b busy=%b want long=0 busy=1", long_pulse, busy);
    end
    while (edge_n < r0 + 39) @(negedge clk);
    key_level = 1'b0;
    repeat (15) @(negedge clk); #1;
    total++;
    if (n_long - s_long != 1 || last_long != r0 + 20) begin
      bad++;
      $display("FAIL long_count: count=%0d edge=%0d want count=1 edge=%0d",
               n_long - s_long, last_long, r0 + 20);
    end
    total++;
    if (n_short != s_short || n_double != s_dbl) begin
      bad++;
      $display("FAIL long_others: short=%0d double=%0d want 0 0",
               n_short - s_short, n_double - s_dbl);
    end
`ifdef KEY_REPEAT_EN
    total++;
    if (rep_q.size() - s_rep != 3) begin
      bad++;
      $display("FAIL repeat_count: got %0d want 3", rep_q.size() - s_rep);
    end else begin
      for (int k = 0; k < 3; k++) begin
        total++;
        if (rep_q[s_rep + k] != r0 + 25 + 5 * k) begin
          bad++;
          $display("FAIL repeat_edge%0d: got %0d want %0d", k, rep_q[s_rep + k], r0 + 25 + 5 * k);
        end
      end
    end
`else
    total++;
    if (rep_q.size() != s_rep) begin
      bad++;
      $display("FAIL repeat_disabled: got %0d pulses want 0", rep_q.size() - s_rep);
    end
`endif
  endtask

  task automatic test_double();
    int s_short = n_short, s_long = n_long, s_dbl = n_double;
    int f1;
    @(negedge clk); key_level = 1'b1;
    repeat (4) @(negedge clk);
    key_level = 1'b0;
    repeat (6) @(negedge clk);
    key_level = 1'b1;
    repeat (4) @(negedge clk);
    key_level = 1'b0; f1 = edge_n + 1;
    while (edge_n < f1) @(negedge clk);
    #1;
    total++;
    if (double_pulse !== 1'b1) begin
      bad++;
      $display("FAIL double_at_release: double_pulse=%b want 1", double_pulse);
    end
    while (edge_n < f1 + 12) @(negedge clk);
    #1;
    total++;
    if (n_double - s_dbl != 1 || last_double != f1) begin
      bad++;
      $display("FAIL double_count: count=%0d edge=%0d want count=1 edge=%0d",
               n_double - s_dbl, last_double, f1);
    end
    total++;
    if (n_short != s_short || n_long != s_long) begin
      bad++;
      $display("FAIL double_others: short=%0d long=%0d want 0 0",
               n_short - s_short, n_long - s_long);
    end
  endtask

  task automatic test_gap_exact();
    int s_short = n_short, s_dbl = n_double;
    int f0, f1;
    @(negedge clk); key_level = 1'b1;
    repeat (4) @(negedge clk);
    key_level = 1'b0; f0 = edge_n + 1;
    repeat (11) @(negedge clk);
    #1;
    total++;
    if (short_pulse !== 1'b1 || edge_n != f0 + 10) begin
      bad++;
      $display("FAIL gap_exact_short: short=%b at edge %0d want 1 at edge %0d",
               short_pulse, edge_n, f0 + 10);
    end
    key_level = 1'b1;
    repeat (4) @(negedge clk);
    key_level = 1'b0; f1 = edge_n + 1;
    while (edge_n < f1 + 12) @(negedge clk);
    #1;
    total++;
    if (n_short - s_short != 2 || last_short != f1 + 10) begin
      bad++;
      $display("FAIL gap_exact_second: shorts=%0d last=%0d want shorts=2 last=%0d",
               n_short - s_short, last_short, f1 + 10);
    end
    total++;
    if (n_double != s_dbl) begin
      bad++;
      $display("FAIL gap_exact_double: got %0d want 0", n_double - s_dbl);
    end
  endtask

  task automatic test_gap_coincide();
    int s_short = n_short, s_dbl = n_double;
    int f0, f1;
    @(negedge clk); key_level = 1'b1;
    repeat (4) @(negedge clk);
    key_level = 1'b0; f0 = edge_n + 1;
    repeat (10) @(negedge clk);
    key_level = 1'b1;
    @(negedge clk); #1;
    total++;
    if (short_pulse !== 1'b0 || edge_n != f0 + 10) begin
      bad++;
      $display("FAIL coincide_no_short: short=%b at edge %0d want 0 at edge %0d",
               short_pulse, edge_n, f0 + 10);
    end
    repeat (3) @(negedge clk);
    key_level = 1'b0; f1 = edge_n + 1;
    while (edge_n < f1 + 12) @(negedge clk);
    #1;
    total++;
    if (n_double - s_dbl != 1 || last_double != f1 || n_short != s_short) begin
      bad++;
      $display("FAIL coincide_double: double=%0d edge=%0d short=%0d want double=1 edge=%0d short=0",
               n_double - s_dbl, last_double, n_short - s_short, f1);
    end
  endtask

  task automatic test_fall_at_threshold();
    int s_short = n_short, s_long = n_long;
    int r0, f0;
    @(negedge clk); key_level = 1'b1; r0 = edge_n + 1;
    repeat (20) @(negedge clk);
    key_level = 1'b0; f0 = edge_n + 1;
    @(negedge clk); #1;
    total++;
    if (long_pulse !== 1'b0 || edge_n != r0 + 20) begin
      bad++;
      $display("FAIL threshold_no_long: long=%b at edge %0d want 0 at edge %0d",
               long_pulse, edge_n, r0 + 20);
    end
    while (edge_n < f0 + 12) @(negedge clk);
    #1;
    total++;
    if (n_long != s_long || n_short - s_short != 1 || last_short != f0 + 10) begin
      bad++;
      $display("FAIL threshold_short: long=%0d short=%0d edge=%0d want long=0 short=1 edge=%0d",
               n_long - s_long, n_short - s_short, last_short, f0 + 10);
    end
  endtask

  task automatic test_reset_mid();
    int s_short, s_long, s_dbl, s_rep;
    int r0, f1;
    @(negedge clk); key_level = 1'b1; r0 = edge_n + 1;
    while (edge_n < r0 + 7) @(negedge clk);
    #1;
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL mid_busy: busy=%b want 1", busy);
    end
    reset = 1'b1;
    #1;
    total++;
    if ({short_pulse, long_pulse, double_pulse, repeat_pulse, busy} !== 5'b0) begin
      bad++;
      $display("FAIL mid_reset_outputs: got %b want 00000",
               {short_pulse, long_pulse, double_pulse, repeat_pulse, busy});
    end
    s_short = n_short; s_long = n_long; s_dbl = n_double; s_rep = rep_q.size();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (40) @(negedge clk);
    #1;
    total++;
    if (n_short != s_short || n_long != s_long || n_double != s_dbl || rep_q.size() != s_rep) begin
      bad++;
      $display("FAIL held_after_reset: short=%0d long=%0d double=%0d repeat=%0d want 0 0 0 0",
               n_short - s_short, n_long - s_long, n_double - s_dbl, rep_q.size() - s_rep);
    end
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL held_after_reset_busy: busy=%b want 0", busy);
    end
    key_level = 1'b0;
    repeat (5) @(negedge clk);
    key_level = 1'b1;
    repeat (4) @(negedge clk);
    key_level = 1'b0; f1 = edge_n + 1;
    while (edge_n < f1 + 10) @(negedge clk);
    #1;
    total++;
    if (short_pulse !== 1'b1) begin
      bad++;
      $display("FAIL new_press_after_reset: short=%b want 1", short_pulse);
    end
    repeat (5) @(negedge clk);
  endtask

  task automatic test_exclusive();
    total++;
    if (n_multi != 0) begin
      bad++;
      $display("FAIL exclusive_pulses: cycles with several pulses=%0d want 0", n_multi);
    end
  endtask

  initial begin
    test_reset();
    test_short();
    test_long();
    test_double();
    test_gap_exact();
    test_gap_coincide();
    test_fall_at_threshold();
    test_reset_mid();
    test_exclusive();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
